// File: rtl/bp_pkg.sv
// Branch-prediction package for the fetch-stage next-PC generator.
// Contents:
//   ctr_t      - 2-bit saturating counter encodings (SNT/WNT/WT/ST)
//   PC_STEP    - sequential fetch increment
//   sat_update - saturating counter step toward the resolved outcome
package bp_pkg;

  typedef enum logic [1:0] {
    SNT = 2'b00,
    WNT = 2'b01,
    WT  = 2'b10,
    ST  = 2'b11
  } ctr_t;

  localparam logic [31:0] PC_STEP = 32'd4;

  // Counter moves one step toward the outcome and sticks at either end.
  function automatic ctr_t sat_update(input ctr_t ctr, input logic taken);
    if (taken) return (ctr == ST)  ? ST  : ctr_t'(ctr + 2'd1);
    else       return (ctr == SNT) ? SNT : ctr_t'(ctr - 2'd1);
  endfunction

endpackage

// File: rtl/f_next_pc_if.sv
// Fetch / EX-resolution bundle for f_next_pc.
//   slave  : the next-PC generator (consumes fetch + EX info, produces PC/prediction)
//   master : the surrounding pipeline (drives fetch + EX info, consumes PC/prediction)
// Signals:
//   stallF, pcF                          - fetch stage state
//   ex_valid/is_branch/is_jump/taken     - resolved control-flow info from EX
//   ex_pc, ex_target                     - resolved PC and actual target
//   ex_pred_taken, ex_pred_target        - prediction carried down the pipe
//   nxt_pc, predF, pred_targetF, flush_req - generator outputs
interface f_next_pc_if;
  logic        stallF;
  logic [31:0] pcF;
  logic        ex_valid;
  logic        ex_is_branch;
  logic        ex_is_jump;
  logic        ex_taken;
  logic [31:0] ex_pc;
  logic [31:0] ex_target;
  logic        ex_pred_taken;
  logic [31:0] ex_pred_target;
  logic [31:0] nxt_pc;
  logic        predF;
  logic [31:0] pred_targetF;
  logic        flush_req;

  modport slave (
    input  stallF, pcF, ex_valid, ex_is_branch, ex_is_jump, ex_taken,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    output nxt_pc, predF, pred_targetF, flush_req
  );

  modport master (
    output stallF, pcF, ex_valid, ex_is_branch, ex_is_jump, ex_taken,
           ex_pc, ex_target, ex_pred_taken, ex_pred_target,
    input  nxt_pc, predF, pred_targetF, flush_req
  );
endinterface

// File: rtl/btb_array.sv
// Direct-mapped BTB storage: valid/tag/target/counter per entry.
// One asynchronous read port (fetch lookup) and one update port (EX
// resolution). The update port carries the resolved outcome and performs
// its own hit check, so the entry's read-modify-write stays local.
// valid and ctr reset asynchronously; tag and target are left unreset.
// Ports:
//   clk, rst                       - clock, async active-high reset
//   i_ridx -> o_rvalid/o_rtag/o_rtgt/o_rctr  - lookup read port
//   i_upd, i_uidx, i_utag, i_utgt, i_utaken, i_ujump - update port
module btb_array
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [$clog2(ENTRIES)-1:0]    i_ridx,
  output logic                          o_rvalid,
  output logic [30-$clog2(ENTRIES)-1:0] o_rtag,
  output logic [31:0]                   o_rtgt,
  output ctr_t                          o_rctr,
  input  logic                          i_upd,
  input  logic [$clog2(ENTRIES)-1:0]    i_uidx,
  input  logic [30-$clog2(ENTRIES)-1:0] i_utag,
  input  logic [31:0]                   i_utgt,
  input  logic                          i_utaken,
  input  logic                          i_ujump
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic            r_valid [ENTRIES];
  ctr_t            r_ctr   [ENTRIES];
  logic [TAGW-1:0] r_tag   [ENTRIES];
  logic [31:0]     r_tgt   [ENTRIES];

  logic w_uhit;
  logic w_tgt_we;

  assign o_rvalid = r_valid[i_ridx];
  assign o_rtag   = r_tag[i_ridx];
  assign o_rtgt   = r_tgt[i_ridx];
  assign o_rctr   = r_ctr[i_ridx];

  assign w_uhit = r_valid[i_uidx] && (r_tag[i_uidx] == i_utag);

  // Target/tag are written on any taken resolution (hit refresh or
  // allocation) and on jump hits. Rewriting the tag on a hit is harmless.
  assign w_tgt_we = i_upd && (i_utaken || (w_uhit && i_ujump));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_valid[i] <= 1'b0;
        r_ctr[i]   <= WNT;
      end
    end else if (i_upd) begin
      if (w_uhit) begin
        r_ctr[i_uidx] <= i_ujump ? ST : sat_update(r_ctr[i_uidx], i_utaken);
      end else if (i_utaken) begin
        r_valid[i_uidx] <= 1'b1;
        r_ctr[i_uidx]   <= i_ujump ? ST : WT;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (w_tgt_we) begin
      r_tag[i_uidx] <= i_utag;
      r_tgt[i_uidx] <= i_utgt;
    end
  end

endmodule

// File: rtl/f_next_pc.sv
// Fetch-stage next-PC generator with a direct-mapped BTB and 2-bit counters.
// Looks up the current pcF, redirects on EX mispredicts, and trains the BTB
// from every resolved branch/jump. All outputs are combinational.
// Optional feature macro: BTB_STATS_EN (adds stat_branches / stat_mispred).
// Ports:
//   clk, rst       - clock, asynchronous active-high reset
//   bus (slave)    - fetch inputs, EX resolution, nxt_pc/predF/pred_targetF/flush_req
//   stat_branches  - (BTB_STATS_EN) count of resolved branch/jump cycles
//   stat_mispred   - (BTB_STATS_EN) count of mispredicts
module f_next_pc
  import bp_pkg::*;
#(
  parameter int ENTRIES = 16
) (
  input  logic        clk,
  input  logic        rst,
  f_next_pc_if.slave  bus
`ifdef BTB_STATS_EN
  ,
  output logic [31:0] stat_branches,
  output logic [31:0] stat_mispred
`endif
);
  localparam int IDXW = $clog2(ENTRIES);
  localparam int TAGW = 30 - IDXW;

  logic [IDXW-1:0] w_idx;
  logic [TAGW-1:0] w_tag;
  logic [IDXW-1:0] w_uidx;
  logic [TAGW-1:0] w_utag;
  logic            w_rvalid;
  logic [TAGW-1:0] w_rtag;
  logic [31:0]     w_rtgt;
  ctr_t            w_rctr;
  logic            w_hit;
  logic            w_upd;
  logic            w_mis;
  logic [31:0]     w_pc_seq;
  logic [31:0]     w_ex_seq;

  assign w_idx  = bus.pcF[IDXW+1:2];
  assign w_tag  = bus.pcF[31:IDXW+2];
  assign w_uidx = bus.ex_pc[IDXW+1:2];
  assign w_utag = bus.ex_pc[31:IDXW+2];

  btb_array #(.ENTRIES(ENTRIES)) u_btb (
    .clk      (clk),
    .rst      (rst),
    .i_ridx   (w_idx),
    .o_rvalid (w_rvalid),
    .o_rtag   (w_rtag),
    .o_rtgt   (w_rtgt),
    .o_rctr   (w_rctr),
    .i_upd    (w_upd),
    .i_uidx   (w_uidx),
    .i_utag   (w_utag),
    .i_utgt   (bus.ex_target),
    .i_utaken (bus.ex_taken),
    .i_ujump  (bus.ex_is_jump)
  );

  // 32-bit adds wrap naturally at the top of the address space.
  assign w_pc_seq = bus.pcF + PC_STEP;
  assign w_ex_seq = bus.ex_pc + PC_STEP;

  // Lookup reads the pre-update entry; no write-to-read bypass.
  assign w_hit            = w_rvalid && (w_rtag == w_tag);
  assign bus.predF        = w_hit && ((w_rctr == WT) || (w_rctr == ST));
  assign bus.pred_targetF = w_hit ? w_rtgt : w_pc_seq;

  assign w_upd = bus.ex_valid && (bus.ex_is_branch || bus.ex_is_jump);
  assign w_mis = w_upd && ((bus.ex_taken != bus.ex_pred_taken) ||
                           (bus.ex_taken && (bus.ex_target != bus.ex_pred_target)));
  assign bus.flush_req = w_mis;

  // Redirect beats a fetch stall so the wrong path is never held.
  always_comb begin
    bus.nxt_pc = w_pc_seq;
    if (w_mis)           bus.nxt_pc = bus.ex_taken ? bus.ex_target : w_ex_seq;
    else if (bus.stallF) bus.nxt_pc = bus.pcF;
    else if (bus.predF)  bus.nxt_pc = bus.pred_targetF;
  end

`ifdef BTB_STATS_EN
  logic [31:0] r_stat_br;
  logic [31:0] r_stat_mis;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_stat_br  <= 32'd0;
      r_stat_mis <= 32'd0;
    end else begin
      if (w_upd) r_stat_br  <= r_stat_br + 32'd1;
      if (w_mis) r_stat_mis <= r_stat_mis + 32'd1;
    end
  end

  assign stat_branches = r_stat_br;
  assign stat_mispred  = r_stat_mis;
`endif

endmodule
